// File: rtl/conv_tile_loader_pkg.sv
// rtl/conv_tile_loader_pkg.sv - shared conv package: pixel/tile types, tile geometry, loader states
package packConv;
   localparam int NBITS  = 16;
   localparam int TILE   = 5;
   localparam int STRIDE = 3;

   typedef logic signed [NBITS-1:0] pix_t;
   typedef pix_t [TILE*TILE-1:0] param25;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } ld_state_e;
endpackage

// File: rtl/conv_tile_loader_if.sv
// rtl/conv_tile_loader_if.sv - pixel stream and conv-engine tile handshake bundle
interface conv_tile_loader_if;
   import packConv::*;

   pix_t   pix_in;
   logic   pix_valid;
   logic   pix_ready;
   logic   conv_start;
   param25 conv_map;
   logic   conv_done;

   modport master (
      input  pix_in, pix_valid, conv_done,
      output pix_ready, conv_start, conv_map
   );

   modport slave (
      output pix_in, pix_valid, conv_done,
      input  pix_ready, conv_start, conv_map
   );
endinterface

// File: rtl/conv_tile_loader_row_buffer.sv
// rtl/conv_tile_loader_row_buffer.sv - 5-row circular pixel store with a combinational 5x5 window read
module tile_row_buffer
   import packConv::*;
#(
   parameter int  IMG_W = 14,
   parameter int  BW    = 2,
   parameter int  TW    = 2,
   localparam int CW    = $clog2(IMG_W)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [2:0]    wrow_i,
   input  logic [CW-1:0] wcol_i,
   input  pix_t          wdata_i,
   input  logic [BW-1:0] band_i,
   input  logic [TW-1:0] tcol_i,
   output param25        window_o
);
   pix_t mem_q [TILE][IMG_W];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[wrow_i][wcol_i] <= wdata_i;
   end

   // The pixel being written this cycle is forwarded so a window loaded on the final accept is complete.
   always_comb begin
      logic [2:0]    prow;
      logic [CW-1:0] pcol;
      prow     = '0;
      pcol     = '0;
      window_o = '0;
      for (int i = 0; i < TILE; i++) begin
         for (int j = 0; j < TILE; j++) begin
            prow = 3'((STRIDE * int'(band_i) + i) % TILE);
            pcol = CW'(STRIDE * int'(tcol_i) + j);
            if (we_i && prow == wrow_i && pcol == wcol_i)
               window_o[i*TILE+j] = wdata_i;
            else
               window_o[i*TILE+j] = mem_q[prow][pcol];
         end
      end
   end
endmodule

// File: rtl/conv_tile_loader.sv
// rtl/conv_tile_loader.sv - row-buffered 5x5/stride-3 tile feeder for the conv engine; STALL_CNT_EN adds stall_cycles
module conv_tile_loader
   import packConv::*;
#(
   parameter int  IMG_W = 14,
   parameter int  IMG_H = 14,
   localparam int TC    = (IMG_W - 2) / STRIDE,
   localparam int TR    = (IMG_H - 2) / STRIDE,
   localparam int TCW   = (TC > 1) ? $clog2(TC) : 1,
   localparam int TRW   = (TR > 1) ? $clog2(TR) : 1,
   localparam int CW    = $clog2(IMG_W)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               go,
   conv_tile_loader_if.master bus,
   output logic [TRW-1:0]     tile_row,
   output logic [TCW-1:0]     tile_col,
   output logic               busy,
   output logic               frame_done
`ifdef STALL_CNT_EN
   ,
   output logic [15:0]        stall_cycles
`endif
);
   if ((IMG_W - TILE) % STRIDE != 0) begin : g_bad_w
      $error("IMG_W-5 must be a multiple of 3");
   end
   if ((IMG_H - TILE) % STRIDE != 0) begin : g_bad_h
      $error("IMG_H-5 must be a multiple of 3");
   end

   ld_state_e      state_q, state_d;
   logic [CW-1:0]  col_q, col_d;
   logic [2:0]     wrow_q, wrow_d;
   logic [2:0]     rows_left_q, rows_left_d;
   logic [TRW-1:0] band_q, band_d;
   logic [TCW-1:0] tcol_q, tcol_d;
   param25         map_q, map_d;

   logic           accept;
   logic           last_col;
   logic [TCW-1:0] rd_tcol;
   param25         window;

   assign accept   = (state_q == ST_LOAD) && bus.pix_valid;
   assign last_col = (col_q == CW'(IMG_W - 1));
   // In WAIT the window is pre-read for the tile that follows the current one.
   assign rd_tcol  = (state_q == ST_WAIT && tcol_q != TCW'(TC - 1)) ? tcol_q + 1'b1 : tcol_q;

   tile_row_buffer #(
      .IMG_W (IMG_W),
      .BW    (TRW),
      .TW    (TCW)
   ) u_buf (
      .clk      (clk),
      .we_i     (accept),
      .wrow_i   (wrow_q),
      .wcol_i   (col_q),
      .wdata_i  (bus.pix_in),
      .band_i   (band_q),
      .tcol_i   (rd_tcol),
      .window_o (window)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         wrow_q      <= '0;
         rows_left_q <= '0;
         band_q      <= '0;
         tcol_q      <= '0;
         map_q       <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         wrow_q      <= wrow_d;
         rows_left_q <= rows_left_d;
         band_q      <= band_d;
         tcol_q      <= tcol_d;
         map_q       <= map_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      wrow_d      = wrow_q;
      rows_left_d = rows_left_q;
      band_d      = band_q;
      tcol_d      = tcol_q;
      map_d       = map_q;
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               state_d     = ST_LOAD;
               col_d       = '0;
               wrow_d      = '0;
               rows_left_d = 3'd5;
               band_d      = '0;
               tcol_d      = '0;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               if (last_col) begin
                  col_d       = '0;
                  wrow_d      = (wrow_q == 3'd4) ? 3'd0 : wrow_q + 3'd1;
                  rows_left_d = rows_left_q - 3'd1;
                  if (rows_left_q == 3'd1) begin
                     state_d = ST_ISSUE;
                     map_d   = window;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (bus.conv_done) begin
               if (tcol_q != TCW'(TC - 1)) begin
                  tcol_d  = tcol_q + 1'b1;
                  map_d   = window;
                  state_d = ST_ISSUE;
               end else if (band_q != TRW'(TR - 1)) begin
                  // Two newest rows stay for the overlap; three fresh rows overwrite the oldest.
                  tcol_d      = '0;
                  band_d      = band_q + 1'b1;
                  rows_left_d = 3'd3;
                  state_d     = ST_LOAD;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.pix_ready  = (state_q == ST_LOAD);
      bus.conv_start = (state_q == ST_ISSUE);
      busy           = (state_q != ST_IDLE);
      frame_done     = (state_q == ST_DONE);
   end

   assign bus.conv_map = map_q;
   assign tile_row     = band_q;
   assign tile_col     = tcol_q;

`ifdef STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_q <= '0;
      else if (state_q == ST_IDLE && go)
         stall_q <= '0;
      else if (state_q == ST_LOAD && !bus.pix_valid && stall_q != 16'hFFFF)
         stall_q <= stall_q + 16'd1;
   end

   assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_conv_tile_loader.sv
// tb/tb_conv_tile_loader.sv - randomized self-checking bench for conv_tile_loader with an image/tile reference model
module tb_conv_tile_loader;
   import packConv::*;

   localparam int W  = 14;
   localparam int H  = 14;
   localparam int TC = 4;
   localparam int TR = 4;
   localparam int NT = TC * TR;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       go    = 1'b0;
   logic [1:0] tile_row;
   logic [1:0] tile_col;
   logic       busy;
   logic       frame_done;
`ifdef STALL_CNT_EN
   logic [15:0] stall_cycles;
`endif

   conv_tile_loader_if bus ();

   conv_tile_loader #(
      .IMG_W (W),
      .IMG_H (H)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .go           (go),
      .bus          (bus),
      .tile_row     (tile_row),
      .tile_col     (tile_col),
      .busy         (busy),
`ifdef STALL_CNT_EN
      .stall_cycles (stall_cycles),
`endif
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   int     total = 0;
   int     bad   = 0;
   pix_t   img [H*W];
   param25 map_log [NT];
   int     starts;
   int     obs_acc;

   function automatic param25 model_tile(int b, int t);
      param25 m;
      for (int k = 0; k < 25; k++)
         m[k] = img[(3*b + k/5)*W + 3*t + k%5];
      return m;
   endfunction

   task automatic run_frame(input bit ramp, input int gap_pct, input int lat_min, input int lat_max,
                            input bit junk, input int abort_tile, input int lead_idle, output bit aborted);
      int accepted, target, band, tcol, cd, cyc, idle_left;
      bit loading, exp_start, exp_fd, acc_prev, done_prev, waiting, finished;
      for (int p = 0; p < H*W; p++) img[p] = ramp ? pix_t'(p) : pix_t'($urandom);
      starts = 0; obs_acc = 0; accepted = 0; target = 5*W; band = 0; tcol = 0; cd = 0; cyc = 0;
      idle_left = lead_idle; acc_prev = 0; done_prev = 0; waiting = 0; finished = 0; aborted = 0;
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      loading = 1;
      while (!finished && cyc < 5000) begin
         cyc++;
         exp_start = 0;
         exp_fd    = 0;
         if (acc_prev) begin
            accepted++;
            if (accepted == target) begin loading = 0; exp_start = 1; end
         end
         if (done_prev) begin
            if (tcol < TC-1) begin tcol++; exp_start = 1; end
            else if (band < TR-1) begin band++; tcol = 0; loading = 1; target += 3*W; end
            else exp_fd = 1;
         end
         total++;
         if (bus.pix_ready !== loading) begin
            bad++; $display("FAIL pix_ready: got %b want %b (band %0d cycle %0d)", bus.pix_ready, loading, band, cyc);
         end
         total++;
         if (bus.conv_start !== exp_start) begin
            bad++; $display("FAIL conv_start: got %b want %b (tile %0d,%0d)", bus.conv_start, exp_start, band, tcol);
         end
         total++;
         if (frame_done !== exp_fd) begin
            bad++; $display("FAIL frame_done: got %b want %b", frame_done, exp_fd);
         end
         total++;
         if (busy !== 1'b1) begin
            bad++; $display("FAIL busy_in_frame: got %b want 1", busy);
         end
         if (exp_start) begin
            total++;
            if (bus.conv_map !== model_tile(band, tcol)) begin
               bad++; $display("FAIL conv_map_%0d_%0d: got %h want %h", band, tcol, bus.conv_map, model_tile(band, tcol));
            end
            total++;
            if (tile_row !== 2'(band) || tile_col !== 2'(tcol)) begin
               bad++; $display("FAIL tile_index: got %0d,%0d want %0d,%0d", tile_row, tile_col, band, tcol);
            end
            map_log[band*TC+tcol] = bus.conv_map;
            starts++;
            waiting = 1;
            cd = $urandom_range(lat_max, lat_min);
            if (band*TC + tcol == abort_tile) begin aborted = 1; finished = 1; end
         end else if (waiting) begin
            total++;
            if (bus.conv_map !== model_tile(band, tcol)) begin
               bad++; $display("FAIL conv_map_hold_%0d_%0d: got %h want %h", band, tcol, bus.conv_map, model_tile(band, tcol));
            end
         end
         if (exp_fd) finished = 1;
         acc_prev = 0; done_prev = 0; bus.conv_done = 1'b0; go = 1'b0;
         if (!finished) begin
            if (waiting && !exp_start) begin
               cd--;
               if (cd == 0) begin bus.conv_done = 1'b1; done_prev = 1; waiting = 0; end
            end
            if (junk && exp_start) bus.conv_done = 1'b1;
            if (junk && loading && $urandom_range(7) == 0) bus.conv_done = 1'b1;
            if (junk && $urandom_range(15) == 0) go = 1'b1;
            if (loading) begin
               if (idle_left > 0) begin idle_left--; bus.pix_valid = 1'b0; end
               else bus.pix_valid = ($urandom_range(99) >= gap_pct);
               bus.pix_in = bus.pix_valid ? img[accepted] : pix_t'($urandom);
               acc_prev = bus.pix_valid;
            end else begin
               bus.pix_valid = 1'($urandom_range(1));
               bus.pix_in    = pix_t'($urandom);
            end
            if (bus.pix_valid && bus.pix_ready) obs_acc++;
            @(posedge clk); #1;
         end
      end
      bus.pix_valid = 1'b0; bus.conv_done = 1'b0; go = 1'b0;
      total++;
      if (!finished) begin
         bad++; $display("FAIL frame_timeout: got %0d tiles want %0d", starts, NT);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (bus.pix_ready !== 1'b0 || bus.conv_start !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
         bad++; $display("FAIL reset_ctrl: got rdy=%b st=%b busy=%b fd=%b want 0", bus.pix_ready, bus.conv_start, busy, frame_done);
      end
      total++;
      if (bus.conv_map !== '0 || tile_row !== 2'd0 || tile_col !== 2'd0) begin
         bad++; $display("FAIL reset_data: got map=%h row=%0d col=%0d want 0", bus.conv_map, tile_row, tile_col);
      end
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || bus.pix_ready !== 1'b0) begin
         bad++; $display("FAIL idle_no_go: got busy=%b rdy=%b want 0", busy, bus.pix_ready);
      end
   endtask

   task automatic test_ramp();
      bit ab;
      int tix[7] = '{0, 0, 0, 1, 4, 4, 15};
      int eix[7] = '{0, 4, 24, 0, 0, 24, 24};
      int val[7] = '{0, 4, 60, 3, 42, 102, 195};
      run_frame(1, 0, 10, 10, 0, -1, 0, ab);
      for (int k = 0; k < 7; k++) begin
         total++;
         if (map_log[tix[k]][eix[k]] !== pix_t'(val[k])) begin
            bad++; $display("FAIL ramp_tile%0d_el%0d: got %0d want %0d", tix[k], eix[k], map_log[tix[k]][eix[k]], val[k]);
         end
      end
      total++;
      if (starts != NT || obs_acc != H*W) begin
         bad++; $display("FAIL ramp_counts: got starts=%0d accepts=%0d want %0d %0d", starts, obs_acc, NT, H*W);
      end
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || frame_done !== 1'b0) begin
         bad++; $display("FAIL ramp_idle: got busy=%b fd=%b want 0", busy, frame_done);
      end
   endtask

   task automatic test_random_gaps();
      bit ab;
      run_frame(0, 40, 1, 12, 0, -1, 0, ab);
      total++;
      if (starts != NT || obs_acc != H*W) begin
         bad++; $display("FAIL gaps_counts: got starts=%0d accepts=%0d want %0d %0d", starts, obs_acc, NT, H*W);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_spurious_done();
      bit ab;
      run_frame(0, 20, 10, 10, 1, -1, 0, ab);
      total++;
      if (starts != NT || obs_acc != H*W) begin
         bad++; $display("FAIL spurious_counts: got starts=%0d accepts=%0d want %0d %0d", starts, obs_acc, NT, H*W);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_frame();
      bit ab;
      bit seen_fd;
      run_frame(0, 10, 6, 6, 0, 2*TC + 1, 0, ab);
      total++;
      if (!ab) begin
         bad++; $display("FAIL abort_reach: got %0d tiles want tile 9 reached", starts);
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      total++;
      if (bus.pix_ready !== 1'b0 || bus.conv_start !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
         bad++; $display("FAIL abort_ctrl: got rdy=%b st=%b busy=%b fd=%b want 0", bus.pix_ready, bus.conv_start, busy, frame_done);
      end
      total++;
      if (bus.conv_map !== '0 || tile_row !== 2'd0 || tile_col !== 2'd0) begin
         bad++; $display("FAIL abort_data: got map=%h row=%0d col=%0d want 0", bus.conv_map, tile_row, tile_col);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      seen_fd = 0;
      for (int c = 0; c < 12; c++) begin
         bus.conv_done = (c == 2);
         @(posedge clk); #1;
         if (frame_done || busy) seen_fd = 1;
      end
      bus.conv_done = 1'b0;
      total++;
      if (seen_fd) begin
         bad++; $display("FAIL abort_quiet: got busy/frame_done activity want none");
      end
      run_frame(1, 0, 3, 3, 0, -1, 0, ab);
      total++;
      if (starts != NT || obs_acc != H*W || map_log[0][24] !== pix_t'(60)) begin
         bad++; $display("FAIL restart: got starts=%0d accepts=%0d t0[24]=%0d want %0d %0d 60", starts, obs_acc, map_log[0][24], NT, H*W);
      end
      @(posedge clk); #1;
   endtask

`ifdef STALL_CNT_EN
   task automatic test_stall_cnt();
      bit ab;
      run_frame(0, 0, 2, 2, 0, -1, 7, ab);
      @(posedge clk); #1;
      total++;
      if (stall_cycles !== 16'd7) begin
         bad++; $display("FAIL stall_count: got %0d want 7", stall_cycles);
      end
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      total++;
      if (stall_cycles !== 16'd0) begin
         bad++; $display("FAIL stall_clear: got %0d want 0", stall_cycles);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      bus.pix_valid = 1'b0;
      bus.pix_in    = '0;
      bus.conv_done = 1'b0;
      test_reset();
      test_ramp();
      test_random_gaps();
      test_spurious_done();
      test_reset_mid_frame();
`ifdef STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
